// File: rtl/result_collector.sv
// result_collector: per-channel result buffer for the systolic core.
// Collects DEPTH results from each of NUM_CH array rows. Each row delivers its
// results on an explicit valid strobe. When every row has delivered DEPTH
// results the tile is complete, and it is drained over a valid/ready stream in
// row-major order.
//
// Optional feature macro: RESULT_COLLECTOR_TRANSPOSE_EN. When it is defined,
// the block adds a `transpose` input. That input selects a column-major drain.
//
// Ports:
//   clk, reset   clock; synchronous active-high reset
//   clear        synchronous abort of the current tile (back to COLLECT)
//   transpose    (macro only) drain column-major; sampled when the tile completes
//   in_valid     per-channel result strobe
//   in_data      per-channel result
//   res_buffer   tile storage, entry c*DEPTH+i
//   full         tile complete, draining
//   overflow     sticky: a strobe was dropped
//   out_valid / out_ready / out_data / out_last   drain stream

module result_collector_lane #(
  parameter int DEPTH = 4,
  parameter int WP_W  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,    // pointer back to 0 (clear or end of drain)
  input  logic            collect,  // block is in COLLECT
  input  logic            abort,    // clear: suppress write and drop reporting
  input  logic            strobe,
  output logic            we,
  output logic            drop,
  output logic            done,     // pointer reaches DEPTH at this edge
  output logic [WP_W-1:0] wr_ptr
);
  logic [WP_W-1:0] wr_ptr_q, wr_ptr_d;

  always_comb begin
    we       = collect && !abort && strobe && (wr_ptr_q < WP_W'(DEPTH));
    drop     = strobe && !abort && !we;
    wr_ptr_d = wr_ptr_q + WP_W'(we);
    done     = (wr_ptr_d == WP_W'(DEPTH));
    if (flush) wr_ptr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) wr_ptr_q <= '0;
    else       wr_ptr_q <= wr_ptr_d;
  end

  assign wr_ptr = wr_ptr_q;
endmodule

module result_collector #(
  parameter int ACCUMULATE = 32,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
`ifdef RESULT_COLLECTOR_TRANSPOSE_EN
  input  logic                  transpose,
`endif
  input  logic [NUM_CH-1:0]     in_valid,
  input  logic [ACCUMULATE-1:0] in_data    [NUM_CH-1:0],
  output logic [ACCUMULATE-1:0] res_buffer [NUM_CH*DEPTH-1:0],
  output logic                  full,
  output logic                  overflow,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACCUMULATE-1:0] out_data,
  output logic                  out_last
);
  localparam int N    = NUM_CH * DEPTH;
  localparam int WP_W = $clog2(DEPTH + 1);
  localparam int RD_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [RD_W-1:0]       rd_idx_q, rd_idx_d;
  logic                  overflow_q, overflow_d;
  logic [ACCUMULATE-1:0] res_buffer_q [N-1:0];
  logic [ACCUMULATE-1:0] res_buffer_d [N-1:0];
`ifdef RESULT_COLLECTOR_TRANSPOSE_EN
  logic                  transpose_q, transpose_d;
`endif

  logic [NUM_CH-1:0]     we, drop, done;
  logic [WP_W-1:0]       wr_ptr [NUM_CH-1:0];
  logic                  collect, xfer, last_xfer, flush;
  logic [RD_W-1:0]       sel;

  assign collect   = (state_q == COLLECT);
  assign xfer      = (state_q == DRAIN) && out_ready;
  assign last_xfer = xfer && (rd_idx_q == RD_W'(N - 1));
  assign flush     = clear || last_xfer;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    result_collector_lane #(.DEPTH(DEPTH), .WP_W(WP_W)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .collect(collect),
      .abort  (clear),
      .strobe (in_valid[c]),
      .we     (we[c]),
      .drop   (drop[c]),
      .done   (done[c]),
      .wr_ptr (wr_ptr[c])
    );
  end

  always_comb begin
    state_d      = state_q;
    rd_idx_d     = rd_idx_q;
    // The lanes already suppress drops under clear, so overflow holds then.
    overflow_d   = overflow_q | (|drop);
    res_buffer_d = res_buffer_q;
`ifdef RESULT_COLLECTOR_TRANSPOSE_EN
    transpose_d  = transpose_q;
`endif

    for (int c = 0; c < NUM_CH; c++) begin
      if (we[c]) res_buffer_d[RD_W'(c * DEPTH) + RD_W'(wr_ptr[c])] = in_data[c];
    end

    if (clear) begin
      state_d  = COLLECT;
      rd_idx_d = '0;
    end else if (state_q == COLLECT) begin
      // done[] already folds in this cycle's writes, so the last write and the
      // transition share one edge.
      if (&done) begin
        state_d = DRAIN;
`ifdef RESULT_COLLECTOR_TRANSPOSE_EN
        transpose_d = transpose;
`endif
      end
    end else if (xfer) begin
      if (last_xfer) begin
        state_d  = COLLECT;
        rd_idx_d = '0;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= COLLECT;
      rd_idx_q     <= '0;
      overflow_q   <= 1'b0;
      res_buffer_q <= '{default: '0};
`ifdef RESULT_COLLECTOR_TRANSPOSE_EN
      transpose_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rd_idx_q     <= rd_idx_d;
      overflow_q   <= overflow_d;
      res_buffer_q <= res_buffer_d;
`ifdef RESULT_COLLECTOR_TRANSPOSE_EN
      transpose_q  <= transpose_d;
`endif
    end
  end

  // Beat k -> entry k (row-major), or (k mod NUM_CH)*DEPTH + k/NUM_CH.
  always_comb begin
    sel = rd_idx_q;
`ifdef RESULT_COLLECTOR_TRANSPOSE_EN
    if (transpose_q)
      sel = RD_W'((int'(rd_idx_q) % NUM_CH) * DEPTH + int'(rd_idx_q) / NUM_CH);
`endif
  end

  assign res_buffer = res_buffer_q;
  assign full       = (state_q == DRAIN);
  assign out_valid  = (state_q == DRAIN);
  assign out_last   = (state_q == DRAIN) && (rd_idx_q == RD_W'(N - 1));
  assign out_data   = res_buffer_q[sel];
  assign overflow   = overflow_q;
endmodule
